prefetch: RTL and testbench
===========================

Name: prefetch

Overview:
- Instruction prefetch unit: the writer end of the instruction byte FIFO that the immediate reader and ModR/M decoder consume.
- Fetches 16-bit words from memory at the physical address formed from CS:IP.
- Splits each word into bytes and pushes them into the FIFO, stalling on full.
- On a control-flow change, flushes the FIFO and refetches from a new CS:IP.

Parameters:
- None. Physical address is fixed at 20 bits, memory bus at 16 bits, FIFO data at 8 bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_new_ip  input  1  one-cycle request to redirect fetch to new_cs:new_ip.
- new_cs  input  16  segment for redirect.
- new_ip  input  16  offset for redirect.
- fifo_wr_en  output  1  FIFO write strobe, combinational.
- fifo_wr_data  output  8  byte written when fifo_wr_en=1.
- fifo_full  input  1  FIFO cannot accept a byte this cycle.
- fifo_reset  output  1  one-cycle synchronous FIFO flush, registered.
- mem_access  output  1  memory read request, held until mem_ack.
- mem_address  output  19  word address, equal to physical[19:1].
- mem_ack  input  1  one-cycle completion; mem_data valid in the same cycle.
- mem_data  input  16  little-endian word: [7:0] is the even byte.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE, cs=16'hFFFF, ip=16'h0000, abort=0.
  - mem_access=0, mem_address=0, fifo_reset=0, fifo_wr_en=0, fifo_wr_data=0, data latch=0.
- Physical address = ({cs,4'b0} + {4'b0,ip}) mod 2^20.
  - mem_address is latched on entry to FETCH and stays stable until mem_ack.
- IP increments by 1 per byte written, wrapping modulo 2^16. CS is unchanged.
- State machine:
  - IDLE: if !fifo_full and !load_new_ip, latch the address and go to FETCH. mem_access=0.
  - FETCH: mem_access=1. On mem_ack, latch mem_data.
    - ip[0]=0: go to WRITE_LO.
    - ip[0]=1: go to WRITE_HI; the low byte is discarded.
  - WRITE_LO: fifo_wr_data=latch[7:0], fifo_wr_en=!fifo_full. On a write, ip++ and go to WRITE_HI.
  - WRITE_HI: fifo_wr_data=latch[15:8], fifo_wr_en=!fifo_full. On a write, ip++ and go to IDLE.
  - WAIT_ABORT: mem_access=1. On mem_ack, discard the data, clear abort, go to IDLE.
- Full stall: while fifo_full=1 in a WRITE state, fifo_wr_en=0 and data, ip and state hold. No fetch is started from IDLE while full.
- Latency: with memory acking in the same cycle it is requested and the FIFO never full, there are 4 cycles per aligned word (IDLE, FETCH, WRITE_LO, WRITE_HI).
- load_new_ip has highest priority in every state:
  - fifo_wr_en is forced to 0 that cycle.
  - Next edge: cs=new_cs, ip=new_ip, fifo_reset=1 for exactly one cycle.
  - In FETCH without mem_ack that cycle: go to WAIT_ABORT and keep mem_access high with the old address. The request is never withdrawn.
  - All other cases go to IDLE, including FETCH with a coincident mem_ack (that data is discarded).
- load_new_ip in WAIT_ABORT: update cs/ip and pulse fifo_reset again. Stay in WAIT_ABORT unless mem_ack is present.
- Reset mid-access: outputs drop immediately. The memory system tolerates a withdrawn request on reset only.

Test Plan:
- Reset fetch:
  - Release reset → mem_access rises with mem_address=19'h7FFF8.
  - Ack mem_data=16'hBBAA → fifo writes 8'hAA then 8'hBB on consecutive cycles.
  - Next fetch address is 19'h7FFF9.
- Odd redirect:
  - load_new_ip with new_cs=16'h1000, new_ip=16'h0003 → fifo_reset pulses once.
  - mem_address=19'h08001; ack 16'h2211 → a single write of 8'h22.
  - Next mem_address=19'h08002.
- Full stall: hold fifo_full=1 during WRITE_HI for 5 cycles → fifo_wr_en=0 with data 8'hBB held; written on the first cycle fifo_full=0. No mem_access while full in IDLE.
- Abort:
  - load_new_ip (cs=0, ip=16'h0100) while mem_access is pending; ack arrives 3 cycles later.
  - mem_access stays high with the old address and none of the acked bytes reach the FIFO.
  - The next fetch is at 19'h00080.
- Wrap:
  - cs=0, ip=16'hFFFE → writes 2 bytes, ip becomes 16'h0000, next address 0.
  - cs=16'hFFFF, ip=16'h0010 → mem_address=0 (20-bit wrap).
- Asynchronous reset asserted during WRITE_LO → fifo_wr_en and mem_access go to 0 without a clock edge. After release, the fetch restarts at 19'h7FFF8.

Source files
------------

// File: rtl/prefetch.sv
// -----------------------------------------------------------------------------
// prefetch -- instruction prefetch unit (writer side of the instruction byte
// FIFO read by the immediate reader and the ModR/M decoder).
//
// Fetches 16-bit little-endian words from the 20-bit physical address formed
// from CS:IP. It splits each word into bytes and pushes them into the FIFO,
// stalling while the FIFO is full. A redirect (load_new_ip) flushes the FIFO
// and restarts fetching at new_cs:new_ip. A memory request that is already
// outstanding is never withdrawn. Instead its data is drained and discarded.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   load_new_ip   one-cycle redirect request (highest priority)
//   new_cs/new_ip redirect target segment/offset
//   fifo_wr_en    FIFO write strobe (combinational)
//   fifo_wr_data  byte presented to the FIFO
//   fifo_full     FIFO cannot accept a byte this cycle
//   fifo_reset    one-cycle registered FIFO flush, follows a redirect
//   mem_access    memory read request, held until mem_ack
//   mem_address   word address = physical[19:1], stable while requesting
//   mem_ack       one-cycle completion, mem_data valid with it
//   mem_data      fetched word, [7:0] is the even-address byte
// -----------------------------------------------------------------------------
module prefetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_new_ip,
  input  logic [15:0] new_cs,
  input  logic [15:0] new_ip,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  input  logic        fifo_full,
  output logic        fifo_reset,
  output logic        mem_access,
  output logic [18:0] mem_address,
  input  logic        mem_ack,
  input  logic [15:0] mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE_LO,
    WRITE_HI,
    WAIT_ABORT
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cs, cs_nxt;
  logic [15:0] ip, ip_nxt;
  logic        abort, abort_nxt;
  logic [15:0] data_q, data_nxt;
  logic [18:0] addr_nxt;
  logic [19:0] phys;

  // The 20-bit sum drops the carry out of bit 19, giving the wrap at 1 MiB.
  assign phys = {cs, 4'b0000} + {4'b0000, ip};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cs          <= 16'hFFFF;
      ip          <= 16'h0000;
      abort       <= 1'b0;
      data_q      <= 16'h0000;
      mem_address <= 19'h0;
      fifo_reset  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cs          <= cs_nxt;
      ip          <= ip_nxt;
      abort       <= abort_nxt;
      data_q      <= data_nxt;
      mem_address <= addr_nxt;
      // Any redirect flushes whatever the FIFO already holds, one cycle later.
      fifo_reset  <= load_new_ip;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt    = state;
    cs_nxt       = cs;
    ip_nxt       = ip;
    abort_nxt    = abort;
    data_nxt     = data_q;
    addr_nxt     = mem_address;
    mem_access   = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = 8'h00;

    unique case (state)
      IDLE: begin
        if (!fifo_full && !load_new_ip) begin
          addr_nxt  = phys[19:1];
          state_nxt = FETCH;
        end
      end

      FETCH: begin
        mem_access = 1'b1;
        if (mem_ack) begin
          data_nxt  = mem_data;
          // An odd IP starts mid-word. The even byte belongs to an earlier
          // address and is skipped.
          state_nxt = ip[0] ? WRITE_HI : WRITE_LO;
        end
      end

      WRITE_LO: begin
        fifo_wr_data = data_q[7:0];
        if (!fifo_full && !load_new_ip) begin
          fifo_wr_en = 1'b1;
          ip_nxt     = ip + 16'd1;
          state_nxt  = WRITE_HI;
        end
      end

      WRITE_HI: begin
        fifo_wr_data = data_q[15:8];
        if (!fifo_full && !load_new_ip) begin
          fifo_wr_en = 1'b1;
          ip_nxt     = ip + 16'd1;
          state_nxt  = IDLE;
        end
      end

      WAIT_ABORT: begin
        // Keep the stale request alive until memory completes it. Its data
        // is dropped.
        mem_access = 1'b1;
        if (mem_ack) begin
          abort_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // A redirect overrides everything above. An unfinished request moves to
    // WAIT_ABORT rather than dropping mem_access.
    if (load_new_ip) begin
      cs_nxt = new_cs;
      ip_nxt = new_ip;
      if ((state == FETCH || state == WAIT_ABORT) && !mem_ack) begin
        state_nxt = WAIT_ABORT;
        abort_nxt = 1'b1;
      end else begin
        state_nxt = IDLE;
        abort_nxt = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prefetch.sv
// -----------------------------------------------------------------------------
// tb_prefetch -- self-checking bench for the prefetch unit.
//
// A memory responder answers requests after a fixed or random latency. Data
// comes from a table, and a hash is used for addresses that are not in the
// table. A reference model tracks the architectural CS:IP and the FIFO flush
// rule. From these it predicts the byte stream and every fetch address:
// each written byte must be the memory byte at (cs*16+ip) mod 2^20, after
// which ip advances. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_new_ip = 1'b0;
  logic [15:0] new_cs = 16'h0;
  logic [15:0] new_ip = 16'h0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_full = 1'b0;
  logic        fifo_reset;
  logic        mem_access;
  logic [18:0] mem_address;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = 16'h0;

  always #5 clk = ~clk;

  prefetch dut (
    .clk          (clk),
    .reset        (reset),
    .load_new_ip  (load_new_ip),
    .new_cs       (new_cs),
    .new_ip       (new_ip),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .fifo_reset   (fifo_reset),
    .mem_access   (mem_access),
    .mem_address  (mem_address),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [15:0] mem_tab [logic [18:0]];

  function automatic logic [15:0] mem_rd(input logic [18:0] a);
    if (mem_tab.exists(a)) return mem_tab[a];
    return {a[7:0] ^ a[15:8] ^ 8'h3C, (a[7:0] + 8'h5B) ^ {5'b0, a[18:16]}};
  endfunction

  function automatic logic [19:0] phys_of(input logic [15:0] s, input logic [15:0] o);
    int unsigned v;
    v = s * 16 + o;
    return v[19:0];
  endfunction

  // ---------------- stimulus state ----------------
  logic        nxt_load = 1'b0;
  logic [15:0] nxt_cs = 16'h0;
  logic [15:0] nxt_ip = 16'h0;
  logic        nxt_full = 1'b0;
  int          lat_fixed = 0;   // <0 selects random latency 0..3
  bit          busy = 0;
  int          wait_cnt = 0;

  // ---------------- reference model state ----------------
  logic [15:0] cs_m, ip_m;
  logic        prev_load, prev_access, prev_full;
  logic [18:0] prev_addr;
  int          nbytes = 0;

  task automatic sb_reset();
    cs_m        = 16'hFFFF;
    ip_m        = 16'h0000;
    prev_load   = 1'b0;
    prev_access = 1'b0;
    prev_full   = 1'b0;
    prev_addr   = 19'h0;
    busy        = 0;
  endtask

  task automatic score();
    logic [19:0] p;
    logic [15:0] w;
    logic [7:0]  eb;
    if (fifo_full)   check("wr_while_full", fifo_wr_en, 1'b0);
    if (load_new_ip) check("wr_during_load", fifo_wr_en, 1'b0);
    check("fifo_reset_pulse", fifo_reset, prev_load);
    if (mem_access && !prev_access) begin
      check("fetch_started_while_full", prev_full, 1'b0);
      p = phys_of(cs_m, ip_m);
      check("fetch_addr", mem_address, p[19:1]);
    end
    if (mem_access && prev_access) check("addr_hold", mem_address, prev_addr);
    if (fifo_wr_en) begin
      p  = phys_of(cs_m, ip_m);
      w  = mem_rd(p[19:1]);
      eb = p[0] ? w[15:8] : w[7:0];
      check("wr_byte", fifo_wr_data, eb);
      ip_m = ip_m + 16'd1;
      nbytes++;
    end
    if (load_new_ip) begin
      cs_m = new_cs;
      ip_m = new_ip;
    end
    prev_load   = load_new_ip;
    prev_access = mem_access;
    prev_full   = fifo_full;
    prev_addr   = mem_address;
  endtask

  // One clock cycle: drive inputs on the falling edge, respond to memory,
  // then sample outputs before the next rising edge.
  task automatic cycle();
    @(negedge clk);
    load_new_ip = nxt_load;
    new_cs      = nxt_cs;
    new_ip      = nxt_ip;
    nxt_load    = 1'b0;
    fifo_full   = nxt_full;
    mem_ack     = 1'b0;
    mem_data    = 16'($urandom);
    if (mem_access) begin
      if (!busy) begin
        busy     = 1;
        wait_cnt = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
      end
      if (wait_cnt == 0) begin
        mem_ack  = 1'b1;
        mem_data = mem_rd(mem_address);
        busy     = 0;
      end else begin
        wait_cnt--;
      end
    end
    #1;
    score();
  endtask

  task automatic wait_access(input string tag);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (mem_access) return;
    end
    check({tag, "_timeout"}, mem_access, 1'b1);
  endtask

  task automatic wait_write(input string tag);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (fifo_wr_en) return;
    end
    check({tag, "_timeout"}, fifo_wr_en, 1'b1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    load_new_ip = 1'b0;
    mem_ack     = 1'b0;
    fifo_full   = 1'b0;
    nxt_full    = 1'b0;
    sb_reset();
    reset = 1'b1;
  endtask

  logic [18:0] old_addr;

  initial begin
    sb_reset();
    mem_tab[19'h7FFF8] = 16'hBBAA;
    mem_tab[19'h08001] = 16'h2211;
    mem_tab[19'h08002] = 16'hBB44;
    mem_tab[19'h08003] = 16'hEEDD;
    mem_tab[19'h00080] = 16'h6655;
    mem_tab[19'h07FFF] = 16'hB2A1;
    mem_tab[19'h00000] = 16'h7788;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_access", mem_access, 1'b0);
    check("rst_mem_address", mem_address, 19'h0);
    check("rst_fifo_reset", fifo_reset, 1'b0);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_wr_data", fifo_wr_data, 8'h00);

    // ---- reset fetch ----
    lat_fixed = 0;
    release_reset();
    wait_access("reset_fetch");
    check("reset_fetch_addr", mem_address, 19'h7FFF8);
    cycle();
    check("reset_wr0_en", fifo_wr_en, 1'b1);
    check("reset_wr0_data", fifo_wr_data, 8'hAA);
    cycle();
    check("reset_wr1_en", fifo_wr_en, 1'b1);
    check("reset_wr1_data", fifo_wr_data, 8'hBB);
    wait_access("second_fetch");
    check("second_fetch_addr", mem_address, 19'h7FFF9);

    // ---- odd redirect ----
    nxt_load = 1'b1; nxt_cs = 16'h1000; nxt_ip = 16'h0003;
    cycle();
    check("redir_no_wr", fifo_wr_en, 1'b0);
    cycle();
    check("redir_fifo_reset_hi", fifo_reset, 1'b1);
    wait_access("odd_fetch");
    check("redir_fifo_reset_lo", fifo_reset, 1'b0);
    check("odd_fetch_addr", mem_address, 19'h08001);
    wait_write("odd_write");
    check("odd_write_data", fifo_wr_data, 8'h22);
    cycle();
    check("odd_single_write", fifo_wr_en, 1'b0);
    wait_access("odd_next_fetch");
    check("odd_next_addr", mem_address, 19'h08002);

    // ---- full stall ----
    wait_write("stall_lo");
    check("stall_lo_data", fifo_wr_data, 8'h44);
    nxt_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_wr_en", fifo_wr_en, 1'b0);
      check("stall_hold_data", fifo_wr_data, 8'hBB);
    end
    nxt_full = 1'b0;
    cycle();
    check("stall_release_en", fifo_wr_en, 1'b1);
    check("stall_release_data", fifo_wr_data, 8'hBB);
    nxt_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("idle_full_no_fetch", mem_access, 1'b0);
    end
    nxt_full  = 1'b0;
    lat_fixed = 3;
    wait_access("pre_abort_fetch");
    check("pre_abort_addr", mem_address, 19'h08003);

    // ---- abort ----
    old_addr = mem_address;
    nxt_load = 1'b1; nxt_cs = 16'h0000; nxt_ip = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("abort_access_held", mem_access, 1'b1);
      check("abort_addr_held", mem_address, old_addr);
      check("abort_no_wr", fifo_wr_en, 1'b0);
    end
    cycle();
    check("abort_released", mem_access, 1'b0);
    lat_fixed = 0;
    wait_access("post_abort_fetch");
    check("post_abort_addr", mem_address, 19'h00080);
    wait_write("post_abort_write");
    check("post_abort_data", fifo_wr_data, 8'h55);

    // ---- wrap ----
    nxt_load = 1'b1; nxt_cs = 16'h0000; nxt_ip = 16'hFFFE;
    cycle();
    wait_access("wrap16_fetch");
    check("wrap16_addr", mem_address, 19'h07FFF);
    wait_write("wrap16_w0");
    check("wrap16_w0_data", fifo_wr_data, 8'hA1);
    cycle();
    check("wrap16_w1_en", fifo_wr_en, 1'b1);
    check("wrap16_w1_data", fifo_wr_data, 8'hB2);
    wait_access("wrap16_next");
    check("wrap16_next_addr", mem_address, 19'h00000);
    nxt_load = 1'b1; nxt_cs = 16'hFFFF; nxt_ip = 16'h0010;
    cycle();
    wait_access("wrap20_fetch");
    check("wrap20_addr", mem_address, 19'h00000);
    wait_write("wrap20_write");
    check("wrap20_data", fifo_wr_data, 8'h88);

    // ---- asynchronous reset during WRITE_LO ----
    #2 reset = 1'b0;
    #1;
    check("async_rst_wr_en", fifo_wr_en, 1'b0);
    check("async_rst_access", mem_access, 1'b0);
    check("async_rst_addr", mem_address, 19'h0);
    release_reset();
    wait_access("restart_fetch");
    check("restart_addr", mem_address, 19'h7FFF8);

    // ---- random traffic ----
    lat_fixed = -1;
    for (int i = 0; i < 3000; i++) begin
      nxt_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) begin
        nxt_load = 1'b1;
        case ($urandom_range(0, 2))
          0:       nxt_cs = 16'hFFFF;
          1:       nxt_cs = 16'h0000;
          default: nxt_cs = 16'($urandom);
        endcase
        case ($urandom_range(0, 2))
          0:       nxt_ip = 16'hFFFE + 16'($urandom_range(0, 1));
          default: nxt_ip = 16'($urandom);
        endcase
      end
      cycle();
    end
    nxt_full = 1'b0;
    repeat (10) cycle();
    check("random_progress", (nbytes > 500), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
